// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx
//   Console byte sink for the PicoRV32 out_byte stream. Bytes are queued in a
//   small registered FIFO and drained as asynchronous serial frames on uart_tx.
//   The default frame is 8N1. Defining OUT_BYTE_UART_PARITY_EN adds an
//   even-parity bit after data bit 7, which makes each frame 11 bit times.
//
// Parameters
//   CLK_DIV  clk cycles per serial bit (2..65535)
//   FIFO_AW  FIFO address width; the FIFO holds 2**FIFO_AW bytes
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   resetn        synchronous active-low reset
//   in_byte       byte to transmit
//   in_byte_en    single-cycle write strobe for in_byte
//   overflow_clr  clears the sticky overflow flag
//   uart_tx       serial line, high when idle
//   busy          high while a frame is in progress
//   fifo_empty    FIFO holds no bytes (registered)
//   fifo_full     FIFO is full (registered)
//   fifo_level    FIFO occupancy (registered)
//   overflow      sticky flag, set when a write was dropped
module out_byte_uart_tx #(
  parameter int CLK_DIV = 104,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       in_byte,
  input  logic             in_byte_en,
  input  logic             overflow_clr,
  output logic             uart_tx,
  output logic             busy,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]      DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW+1)'(1);

`ifdef OUT_BYTE_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
                            PARITY = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr, r_level;
  logic             r_empty, r_full, r_ovf;

  logic             w_pop, w_push, w_drop;
  logic [FIFO_AW:0] w_wptr_nxt, w_rptr_nxt, w_level_nxt;

  // A write into a full FIFO still lands if the TX side pops on the same edge.
  // When the FIFO is full, the write slot and the head slot are the same entry.
  // The head is read from the old contents, so no byte is lost.
  assign w_push      = in_byte_en & (~r_full | w_pop);
  assign w_drop      = in_byte_en & r_full & ~w_pop;
  assign w_wptr_nxt  = w_push ? r_wptr + PTR_ONE : r_wptr;
  assign w_rptr_nxt  = w_pop  ? r_rptr + PTR_ONE : r_rptr;
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= in_byte;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LVL_FULL);
      // A drop takes priority over a clear in the same cycle.
      if (w_drop)            r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt, w_bit_inc;
  logic [7:0]  r_data;
  logic        r_tx, w_tx_nxt, w_cnt_end;

  assign w_cnt_end = (r_cnt == DIV_M1);
  assign w_bit_inc = r_bit + 3'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      if (w_pop) r_data <= r_mem[r_rptr[FIFO_AW-1:0]];
    end
  end

  // uart_tx is registered. Each transition drives the value of the next bit
  // on the edge that enters that bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt  = 1'b1;
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_data[0];
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
`ifdef OUT_BYTE_UART_PARITY_EN
            w_tx_nxt    = ^r_data;
            w_state_nxt = PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = r_data[w_bit_inc];
          end
        end
      end
`ifdef OUT_BYTE_UART_PARITY_EN
      PARITY: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign uart_tx    = r_tx;
  assign busy       = (r_state != IDLE);
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_out_byte_uart_tx.sv
module tb_out_byte_uart_tx;

  localparam int DIV = 4;
  localparam int AW  = 4;
`ifdef OUT_BYTE_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk;
  logic          resetn;
  logic [7:0]    in_byte;
  logic          in_byte_en;
  logic          overflow_clr;
  logic          uart_tx, busy, fifo_empty, fifo_full, overflow;
  logic [AW:0]   fifo_level;

  int n_chk = 0;
  int n_err = 0;

  out_byte_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_byte      (in_byte),
    .in_byte_en   (in_byte_en),
    .overflow_clr (overflow_clr),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Check one frame whose start-bit edge was start_off cycles ago. Each bit is
  // sampled in the middle of its bit time. The task then lands exactly on the
  // frame-end edge and checks whether the next frame starts or the line goes idle.
  task automatic check_frame(input logic [7:0] b, input int start_off, input bit last,
                             input string tag);
    logic [10:0] bits;
    int cur;
`ifdef OUT_BYTE_UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b0, 1'b1, b, 1'b0};
`endif
    cur = start_off;
    for (int k = 0; k < NB; k++) begin
      int t;
      t = DIV * k + DIV / 2;
      if (t >= cur) begin
        ticks(t - cur);
        cur = t;
        chk($sformatf("%s_bit%0d", tag, k), uart_tx, bits[k]);
      end
    end
    chk({tag, "_busy_in_stop"}, busy, 1);
    ticks(DIV * NB - cur);
    if (last) begin
      chk({tag, "_end_tx"}, uart_tx, 1);
      chk({tag, "_end_busy"}, busy, 0);
    end else begin
      chk({tag, "_next_start"}, uart_tx, 0);
      chk({tag, "_next_busy"}, busy, 1);
    end
  endtask

  initial begin
    logic [7:0] cur_b;
    int stray;
    resetn = 1'b0; in_byte = '0; in_byte_en = 1'b0; overflow_clr = 1'b0;
    ticks(3);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    resetn = 1'b1;
    ticks(2);

    // Single byte: the start edge falls two edges after the write.
    in_byte = 8'h55; in_byte_en = 1'b1; tick(); in_byte_en = 1'b0;
    chk("t1_level1", fifo_level, 1);
    chk("t1_nempty", fifo_empty, 0);
    chk("t1_tx_hi", uart_tx, 1);
    tick();
    chk("t1_start", uart_tx, 0);
    chk("t1_busy", busy, 1);
    chk("t1_level0", fifo_level, 0);
    check_frame(8'h55, 0, 1'b1, "t1");
    chk("t1_empty_end", fifo_empty, 1);
    ticks(5);

    // Burst of three writes on consecutive cycles.
    in_byte = 8'h01; in_byte_en = 1'b1; tick();
    in_byte = 8'h02; tick();
    in_byte = 8'h03; tick(); in_byte_en = 1'b0;
    chk("t2_level_peak", fifo_level, 2);
    check_frame(8'h01, 1, 1'b0, "t2a");
    check_frame(8'h02, 0, 1'b0, "t2b");
    check_frame(8'h03, 0, 1'b1, "t2c");
    chk("t2_level_end", fifo_level, 0);
    ticks(5);

    // Overflow: bytes 0..19 back to back. Byte 0 is popped first, so 0..16 fit.
    for (int j = 0; j < 20; j++) begin
      in_byte = 8'(j); in_byte_en = 1'b1; tick();
      if (j == 16) begin
        chk("t3_full", fifo_full, 1);
        chk("t3_level16", fifo_level, 16);
        chk("t3_ovf_pre", overflow, 0);
      end
      if (j == 17) chk("t3_ovf_set", overflow, 1);
    end
    in_byte_en = 1'b0;
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    check_frame(8'h00, 19, 1'b0, "t3_0");
    for (int j = 1; j <= 16; j++)
      check_frame(8'(j), 0, (j == 16), $sformatf("t3_%0d", j));
    chk("t3_empty_end", fifo_empty, 1);
    ticks(5);

    // Full plus pop: write on the exact edge where STOP ends and pops.
    for (int j = 0; j < 17; j++) begin
      in_byte = 8'h10 + 8'(j); in_byte_en = 1'b1; tick();
    end
    in_byte_en = 1'b0;
    chk("t4_full", fifo_full, 1);
    ticks(DIV * NB - 16);
    in_byte = 8'hAA; in_byte_en = 1'b1; tick(); in_byte_en = 1'b0;
    chk("t4_level_hold", fifo_level, 16);
    chk("t4_full_hold", fifo_full, 1);
    chk("t4_ovf_zero", overflow, 0);
    chk("t4_restart", uart_tx, 0);
    in_byte = 8'hBB; in_byte_en = 1'b1; tick(); in_byte_en = 1'b0;
    chk("t4_drop_ovf", overflow, 1);
    chk("t4_drop_level", fifo_level, 16);

    // Reset during data bit 3 of the second frame (byte 0x11).
    ticks(16);
    cur_b = 8'h11;
    chk("t5_bit3", uart_tx, cur_b[3]);
    chk("t5_busy_pre", busy, 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("t5_tx", uart_tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_full", fifo_full, 0);
    stray = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (uart_tx !== 1'b1 || busy !== 1'b0) stray++;
    end
    chk("t5_quiet", stray, 0);

    // 0x07 then 0x03; with parity enabled the parity bits are 1 and 0.
    in_byte = 8'h07; in_byte_en = 1'b1; tick();
    in_byte = 8'h03; tick(); in_byte_en = 1'b0;
    check_frame(8'h07, 0, 1'b0, "t6a");
    check_frame(8'h03, 0, 1'b1, "t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
